// File: rtl/sobel_magnitude.sv
// L1 gradient magnitude with saturation, edge threshold, border blanking and end-of-line tagging.
// Three-stage elastic pipeline with valid/ready on both sides.
module sobel_magnitude #(
    parameter int unsigned WIDTH_P  = 8,
    parameter int unsigned DEPTH_P  = 16,
    parameter int unsigned HEIGHT_P = 16,
    parameter int unsigned SHIFT_P  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [2*WIDTH_P-1:0] gx_i,
    input  logic [2*WIDTH_P-1:0] gy_i,
    input  logic [WIDTH_P-1:0]   thresh_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH_P-1:0]   mag_o,
    output logic                 edge_o,
    output logic                 eol_o
);

    localparam int unsigned GW = 2 * WIDTH_P;
    localparam int unsigned AW = GW - 1;
    localparam int unsigned CW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
    localparam int unsigned RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
    localparam logic [GW-1:0] MAX_PIX = {{(GW - WIDTH_P){1'b0}}, {WIDTH_P{1'b1}}};

    // The most negative code has no positive twin; clamp it to the largest magnitude.
    function automatic logic [AW-1:0] abs_sat(input logic [GW-1:0] g);
        logic [GW-1:0] neg;
        logic [AW-1:0] res;
        neg = ~g + GW'(1);
        if (!g[GW-1]) begin
            res = g[AW-1:0];
        end else if (g[AW-1:0] == '0) begin
            res = '1;
        end else begin
            res = neg[AW-1:0];
        end
        return res;
    endfunction

    logic               v1_q, v1_d, b1_q, b1_d, e1_q, e1_d;
    logic [AW-1:0]      ax1_q, ax1_d, ay1_q, ay1_d;
    logic               v2_q, v2_d, b2_q, b2_d, e2_q, e2_d;
    logic [WIDTH_P-1:0] m2_q, m2_d;
    logic               v3_q, v3_d, edge3_q, edge3_d, eol3_q, eol3_d;
    logic [WIDTH_P-1:0] mag3_q, mag3_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;

    logic          en1, en2, en3, accept;
    logic [GW-1:0] sum, shifted;

    always_comb begin
        en3     = ~v3_q | ready_i;
        en2     = ~v2_q | en3;
        en1     = ~v1_q | en2;
        ready_o = en1;
        accept  = valid_i & en1;

        v1_d = v1_q;  b1_d = b1_q;  e1_d = e1_q;  ax1_d = ax1_q;  ay1_d = ay1_q;
        v2_d = v2_q;  b2_d = b2_q;  e2_d = e2_q;  m2_d = m2_q;
        v3_d = v3_q;  mag3_d = mag3_q;  edge3_d = edge3_q;  eol3_d = eol3_q;
        col_d = col_q;  row_d = row_q;

        sum     = {1'b0, ax1_q} + {1'b0, ay1_q};
        shifted = sum >> SHIFT_P;

        if (en1) begin
            v1_d = valid_i;
            if (valid_i) begin
                ax1_d = abs_sat(gx_i);
                ay1_d = abs_sat(gy_i);
                b1_d  = (32'(col_q) < 32'd2) || (32'(row_q) < 32'd2);
                e1_d  = (32'(col_q) == DEPTH_P - 1);
            end
        end

        if (en2) begin
            v2_d = v1_q;
            if (v1_q) begin
                m2_d = (shifted > MAX_PIX) ? '1 : shifted[WIDTH_P-1:0];
                b2_d = b1_q;
                e2_d = e1_q;
            end
        end

        if (en3) begin
            v3_d = v2_q;
            if (v2_q) begin
                mag3_d  = b2_q ? '0 : m2_q;
                edge3_d = ~b2_q & (m2_q >= thresh_i);
                eol3_d  = e2_q;
            end
        end

        if (accept) begin
            if (32'(col_q) == DEPTH_P - 1) begin
                col_d = '0;
                row_d = (32'(row_q) == HEIGHT_P - 1) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q <= 1'b0;  b1_q <= 1'b0;  e1_q <= 1'b0;  ax1_q <= '0;  ay1_q <= '0;
            v2_q <= 1'b0;  b2_q <= 1'b0;  e2_q <= 1'b0;  m2_q <= '0;
            v3_q <= 1'b0;  mag3_q <= '0;  edge3_q <= 1'b0;  eol3_q <= 1'b0;
            col_q <= '0;  row_q <= '0;
        end else begin
            v1_q <= v1_d;  b1_q <= b1_d;  e1_q <= e1_d;  ax1_q <= ax1_d;  ay1_q <= ay1_d;
            v2_q <= v2_d;  b2_q <= b2_d;  e2_q <= e2_d;  m2_q <= m2_d;
            v3_q <= v3_d;  mag3_q <= mag3_d;  edge3_q <= edge3_d;  eol3_q <= eol3_d;
            col_q <= col_d;  row_q <= row_d;
        end
    end

    assign valid_o = v3_q;
    assign mag_o   = mag3_q;
    assign edge_o  = edge3_q;
    assign eol_o   = eol3_q;

endmodule

// File: tb/tb_sobel_magnitude.sv
// Directed bench for sobel_magnitude: one DUT with SHIFT_P=0 and one with SHIFT_P=3 on a shared stream.
module tb_sobel_magnitude;

    logic        clk, rst_i, valid_i, ready_i;
    logic [15:0] gx_i, gy_i;
    logic [7:0]  thresh_i;
    logic        ready_o, valid_o, edge_o, eol_o;
    logic [7:0]  mag_o;
    logic        ready3_o, valid3_o, edge3_o, eol3_o;
    logic [7:0]  mag3_o;

    sobel_magnitude #(.WIDTH_P(8), .DEPTH_P(16), .HEIGHT_P(16), .SHIFT_P(0)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .gx_i(gx_i), .gy_i(gy_i), .thresh_i(thresh_i), .valid_o(valid_o),
        .ready_i(ready_i), .mag_o(mag_o), .edge_o(edge_o), .eol_o(eol_o)
    );

    sobel_magnitude #(.WIDTH_P(8), .DEPTH_P(16), .HEIGHT_P(16), .SHIFT_P(3)) dut_s3 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready3_o),
        .gx_i(gx_i), .gy_i(gy_i), .thresh_i(thresh_i), .valid_o(valid3_o),
        .ready_i(ready_i), .mag_o(mag3_o), .edge_o(edge3_o), .eol_o(eol3_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int stalls = 0;
    int mcol = 0;
    int mrow = 0;
    // Entries are {mag[7:0], edge, eol}
    logic [9:0] obs[$], obs3[$], exp0[$], exp3[$];

    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i) obs.push_back({mag_o, edge_o, eol_o});
        if (!rst_i && valid3_o && ready_i) obs3.push_back({mag3_o, edge3_o, eol3_o});
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    function automatic logic [9:0] model(input int gx, input int gy, input int sh, input int thr,
                                         input bit border, input bit eol);
        int ax, ay, s;
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        if (ax > 32767) ax = 32767;
        if (ay > 32767) ay = 32767;
        s = (ax + ay) >>> sh;
        if (s > 255) s = 255;
        if (border) return {8'd0, 1'b0, eol};
        return {8'(s), (s >= thr), eol};
    endfunction

    task automatic push(input int gx, input int gy);
        int n;
        logic acc;
        bit border, eol;
        n = 0;
        acc = 1'b0;
        valid_i = 1'b1;
        gx_i = 16'(gx);
        gy_i = 16'(gy);
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        valid_i = 1'b0;
        if (n > 1) stalls += n - 1;
        chk("accept", 32'(acc), 32'd1);
        border = (mcol < 2) || (mrow < 2);
        eol = (mcol == 15);
        exp0.push_back(model(gx, gy, 0, int'(thresh_i), border, eol));
        exp3.push_back(model(gx, gy, 3, int'(thresh_i), border, eol));
        if (mcol == 15) begin
            mcol = 0;
            mrow = (mrow == 15) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    task automatic wait_drain(input int n);
        int k;
        k = 0;
        while ((obs.size() < n || obs3.size() < n) && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_cnt", obs.size(), n);
        chk("drain_cnt_s3", obs3.size(), n);
        if (obs.size() != n || obs3.size() != n) begin
            $display("[TB] %0d tests run, %0d failed", tests, failed);
            $fatal(1, "output count wrong, stopping");
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < exp0.size(); i++) begin
            chk($sformatf("out[%0d]", i), obs[i], exp0[i]);
            chk($sformatf("out_s3[%0d]", i), obs3[i], exp3[i]);
        end
        obs.delete(); obs3.delete(); exp0.delete(); exp3.delete();
    endtask

    initial begin
        int gx, gy, neol;
        logic [9:0] snap;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        gx_i = '0; gy_i = '0; thresh_i = 8'd128;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_mag", mag_o, 0);
        chk("rst_edge", edge_o, 0);
        chk("rst_eol", eol_o, 0);
        chk("rst_ready", ready_o, 1);

        // Frame: 290 inputs, latency probe on the first one.
        push(500, 500);
        chk("lat_a", valid_o, 0);
        @(posedge clk); #1;
        chk("lat_b", valid_o, 0);
        @(posedge clk); #1;
        chk("lat_c", valid_o, 1);
        for (int i = 1; i < 290; i++) begin
            gx = 500; gy = 500;
            case (i)
                37: begin gx = 100;    gy = -50; end
                38: begin gx = 60;     gy = -50; end
                39: begin gx = -32768; gy = 0;   end
                40: begin gx = 200;    gy = 100; end
                41: begin gx = 2040;   gy = 0;   end
                42: begin gx = 64;     gy = -16; end
                default: ;
            endcase
            push(gx, gy);
        end
        chk("no_bubbles", stalls, 0);
        wait_drain(290);
        chk("mag37", obs[37], {8'd150, 1'b1, 1'b0});
        chk("mag38", obs[38], {8'd110, 1'b0, 1'b0});
        chk("sat_min", obs[39], {8'd255, 1'b1, 1'b0});
        chk("sat_sum", obs[40], {8'd255, 1'b1, 1'b0});
        chk("s3_sat", obs3[41], {8'd255, 1'b1, 1'b0});
        chk("s3_div", obs3[42], {8'd10, 1'b0, 1'b0});
        chk("s3_500", obs3[34], {8'd125, 1'b0, 1'b0});
        chk("brd32", obs[32], {8'd0, 1'b0, 1'b0});
        chk("brd33", obs[33], {8'd0, 1'b0, 1'b0});
        chk("brd48", obs[48], {8'd0, 1'b0, 1'b0});
        chk("in34", obs[34], {8'd255, 1'b1, 1'b0});
        chk("eol15", obs[15], {8'd0, 1'b0, 1'b1});
        chk("eol255", obs[255], {8'd255, 1'b1, 1'b1});
        chk("wrap256", obs[256], {8'd0, 1'b0, 1'b0});
        chk("eol270", obs[270], {8'd0, 1'b0, 1'b0});
        chk("eol271", obs[271], {8'd0, 1'b0, 1'b1});
        neol = 0;
        for (int i = 0; i < 290; i++) begin
            snap = obs[i];
            if (snap[0]) neol++;
        end
        chk("eol_count", neol, 18);
        compare_all();

        // Backpressure at row 2 col 2 onward, threshold 0.
        thresh_i = 8'd0;
        push(100, 0);
        push(0, 0);
        push(10, 20);
        ready_i = 1'b0;
        #1;
        chk("stall_ready", ready_o, 0);
        snap = {mag_o, edge_o, eol_o};
        chk("stall_snap", snap, {8'd100, 1'b1, 1'b0});
        valid_i = 1'b1; gx_i = 16'(-5); gy_i = 16'(3);
        for (int c = 0; c < 5; c++) begin
            chk("stall_ready_c", ready_o, 0);
            chk("stall_valid", valid_o, 1);
            chk("stall_hold", {mag_o, edge_o, eol_o}, snap);
            chk("stall_hold_s3", mag3_o, 12);
            @(posedge clk); #1;
        end
        ready_i = 1'b1;
        push(-5, 3);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        push(1, -1);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        push(0, -7);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        push(-300, 0);
        push(50, 50);
        wait_drain(8);
        chk("bp0", obs[0], {8'd100, 1'b1, 1'b0});
        chk("thr0_zero", obs[1], {8'd0, 1'b1, 1'b0});
        chk("bp2", obs[2], {8'd30, 1'b1, 1'b0});
        chk("bp3", obs[3], {8'd8, 1'b1, 1'b0});
        compare_all();

        // Reset mid-frame after 20 back-to-back accepts.
        thresh_i = 8'd128;
        for (int i = 0; i < 20; i++) push(500, 500);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        #1;
        chk("mrst_valid", valid_o, 0);
        chk("mrst_mag", mag_o, 0);
        chk("mrst_ready", ready_o, 1);
        chk("mrst_delivered", obs.size(), 17);
        while (exp0.size() > 17) void'(exp0.pop_back());
        while (exp3.size() > 17) void'(exp3.pop_back());
        mcol = 0;
        mrow = 0;
        for (int i = 0; i < 16; i++) push(500, 500);
        wait_drain(33);
        chk("mrst_first", obs[17], {8'd0, 1'b0, 1'b0});
        chk("mrst_eol", obs[32], {8'd0, 1'b0, 1'b1});
        compare_all();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
